tpu_sequencer: RTL

- Central control FSM for the matrix-multiply unit. Replaces the ad-hoc start counter and address-range enables that currently sit in the top level.
- Accepts MMIO requests over a valid/ready handshake and decodes the address map (A rows, B rows, C half-rows, start, status).
- Drives registered enables to memA, memB and the systolic array.
- Sequences the compute phase and back-pressures the host while compute is busy.

---
 rtl/tpu_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_sequencer.sv
// ============================================================================
// Module   : tpu_sequencer
// Purpose  : MMIO decode and compute-phase control FSM for the matrix unit.
//            Optional IRQ output is enabled with the TPU_SEQ_IRQ_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpu_sequencer #(
  parameter int DIM   = 8,
  parameter int ADDRW = 16,
  parameter int DATAW = 64,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDRW-1:0]       req_addr,
  output logic                   a_wr_en,
  output logic [$clog2(DIM)-1:0] a_row,
  output logic                   a_en,
  output logic                   b_en,
  output logic                   sa_en,
  output logic                   sa_wr_en,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic                   c_high,
  output logic                   rd_valid,
  output logic                   rd_is_status,
  output logic [DATAW-1:0]       status,
  output logic                   done
`ifdef TPU_SEQ_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int RW   = $clog2(DIM);
  localparam int CW   = $clog2(3 * DIM);
  localparam int PADW = DATAW - CNTW - 3;
  localparam logic [CW-1:0] C_LAST = CW'(3 * DIM - 3);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [ADDRW-1:0] C_A_LO  = ADDRW'('h100);
  localparam logic [ADDRW-1:0] C_A_HI  = ADDRW'('h13F);
  localparam logic [ADDRW-1:0] C_B_LO  = ADDRW'('h200);
  localparam logic [ADDRW-1:0] C_B_HI  = ADDRW'('h23F);
  localparam logic [ADDRW-1:0] C_C_LO  = ADDRW'('h300);
  localparam logic [ADDRW-1:0] C_C_HI  = ADDRW'('h37F);
  localparam logic [ADDRW-1:0] C_START = ADDRW'('h400);
  localparam logic [ADDRW-1:0] C_STAT  = ADDRW'('h408);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            a_wr_en_q, a_wr_en_d;
  logic            a_en_q, a_en_d;
  logic            b_en_q, b_en_d;
  logic            sa_en_q, sa_en_d;
  logic            sa_wr_en_q, sa_wr_en_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_is_status_q, rd_is_status_d;
  logic            done_q, done_d;
  logic [RW-1:0]   a_row_q, a_row_d;
  logic [RW-1:0]   c_row_q, c_row_d;
  logic            c_high_q, c_high_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] done_cnt_q, done_cnt_d;
  logic            irq_bit;
`ifdef TPU_SEQ_IRQ_EN
  logic            irq_q, irq_d;
`endif

  logic in_a, in_b, in_c, is_start, in_ctl;

  assign in_a     = (req_addr >= C_A_LO) && (req_addr <= C_A_HI);
  assign in_b     = (req_addr >= C_B_LO) && (req_addr <= C_B_HI);
  assign in_c     = (req_addr >= C_C_LO) && (req_addr <= C_C_HI);
  assign is_start = (req_addr == C_START);
  // Status/control window 0x408-0x40B; low address bits act as clear commands.
  assign in_ctl   = ({req_addr[ADDRW-1:2], 2'b00} == C_STAT);

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    a_wr_en_d      = 1'b0;
    a_en_d         = 1'b0;
    b_en_d         = 1'b0;
    sa_en_d        = 1'b0;
    sa_wr_en_d     = 1'b0;
    rd_valid_d     = 1'b0;
    rd_is_status_d = 1'b0;
    done_d         = 1'b0;
    a_row_d        = a_row_q;
    c_row_d        = c_row_q;
    c_high_d       = c_high_q;
    err_d          = err_q;
    done_cnt_d     = done_cnt_q;
`ifdef TPU_SEQ_IRQ_EN
    irq_d          = irq_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            if (in_a) begin
              a_wr_en_d = 1'b1;
              a_row_d   = req_addr[3 +: RW];
            end else if (in_b) begin
              b_en_d = 1'b1;
            end else if (in_c) begin
              sa_wr_en_d = 1'b1;
              c_row_d    = req_addr[4 +: RW];
              c_high_d   = req_addr[3];
            end else if (is_start) begin
              state_d = S_COMPUTE;
              count_d = '0;
              a_en_d  = 1'b1;
              b_en_d  = 1'b1;
              sa_en_d = 1'b1;
            end else if (in_ctl && (req_addr[1:0] != 2'b00)) begin
              if (req_addr[0]) err_d = 1'b0;
`ifdef TPU_SEQ_IRQ_EN
              if (req_addr[1]) irq_d = 1'b0;
`endif
            end else begin
              err_d = 1'b1;
            end
          end else begin
            rd_valid_d = 1'b1;
            if (in_c) begin
              c_row_d  = req_addr[4 +: RW];
              c_high_d = req_addr[3];
            end else begin
              // Unmapped reads still answer with status so the host never stalls.
              rd_is_status_d = 1'b1;
              if (req_addr != C_STAT) err_d = 1'b1;
            end
          end
        end
      end
      S_COMPUTE: begin
        if (count_q == C_LAST) begin
          state_d    = S_DONE;
          count_d    = '0;
          done_d     = 1'b1;
          done_cnt_d = done_cnt_q + CNTW'(1);
`ifdef TPU_SEQ_IRQ_EN
          irq_d      = 1'b1;
`endif
        end else begin
          count_d = count_q + CW'(1);
          a_en_d  = 1'b1;
          b_en_d  = 1'b1;
          sa_en_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      a_wr_en_q      <= 1'b0;
      a_en_q         <= 1'b0;
      b_en_q         <= 1'b0;
      sa_en_q        <= 1'b0;
      sa_wr_en_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_is_status_q <= 1'b0;
      done_q         <= 1'b0;
      a_row_q        <= '0;
      c_row_q        <= '0;
      c_high_q       <= 1'b0;
      err_q          <= 1'b0;
      done_cnt_q     <= '0;
`ifdef TPU_SEQ_IRQ_EN
      irq_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      a_wr_en_q      <= a_wr_en_d;
      a_en_q         <= a_en_d;
      b_en_q         <= b_en_d;
      sa_en_q        <= sa_en_d;
      sa_wr_en_q     <= sa_wr_en_d;
      rd_valid_q     <= rd_valid_d;
      rd_is_status_q <= rd_is_status_d;
      done_q         <= done_d;
      a_row_q        <= a_row_d;
      c_row_q        <= c_row_d;
      c_high_q       <= c_high_d;
      err_q          <= err_d;
      done_cnt_q     <= done_cnt_d;
`ifdef TPU_SEQ_IRQ_EN
      irq_q          <= irq_d;
`endif
    end
  end

`ifdef TPU_SEQ_IRQ_EN
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign req_ready    = (state_q == S_IDLE);
  assign a_wr_en      = a_wr_en_q;
  assign a_row        = a_row_q;
  assign a_en         = a_en_q;
  assign b_en         = b_en_q;
  assign sa_en        = sa_en_q;
  assign sa_wr_en     = sa_wr_en_q;
  assign c_row        = c_row_q;
  assign c_high       = c_high_q;
  assign rd_valid     = rd_valid_q;
  assign rd_is_status = rd_is_status_q;
  assign done         = done_q;
  assign status       = {{PADW{1'b0}}, irq_bit, err_q, (state_q != S_IDLE), done_cnt_q};

endmodule

`default_nettype wire
